alu_arbiter: RTL and testbench

Sequencing controller that shares one `alu` datapath between two requesters. It accepts operations over valid/ready handshakes and arbitrates round-robin. It drives operands and `alu_code` to the ALU, toggles the ALU's level-sensitive `enable` to trigger evaluation, waits a fixed settle time, then captures the result and overflow and returns them to the granted requester. It sits between the instruction-issue logic and the ALU instance.

---
 rtl/alu_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 19 +
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the ALU sequencing arbiter
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arbState_e;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_CODE_W = 5;

    // Operation group carried in alu_code[4:3]
    localparam logic [1:0] ALU_GRP_ARITH = 2'b00;
    localparam logic [1:0] ALU_GRP_LOGIC = 2'b01;
    localparam logic [1:0] ALU_GRP_SHIFT = 2'b10;
    localparam logic [1:0] ALU_GRP_CMP   = 2'b11;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin grant
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       lastGrant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie the requester that did not win last time goes next
            2'b11:   grant = lastGrant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters, round-robin, enable-toggle triggered
// Defining ALU_ARB_STATS_EN adds saturating grant and overflow counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int CODE_W        = DEFAULT_CODE_W,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CODE_W-1:0] req0_code,
    input  logic [CODE_W-1:0] req1_code,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_c,
    output logic              rsp_overflow,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CODE_W-1:0] alu_code,
    output logic              alu_enable,
    input  logic [WIDTH-1:0]  alu_c,
    input  logic              alu_overflow,
    output logic              busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
    output logic [15:0]       ovf_cnt
`endif
);

    arbState_e  state;
    logic       lastGrant;
    logic       owner;
    logic [1:0] grant;
    logic       accept;
    logic       capture;
    logic [3:0] settleCnt;

    rr_arb2 uArb (
        .valid     ({req1_valid, req0_valid}),
        .lastGrant (lastGrant),
        .grant     (grant)
    );

    assign accept     = (state == IDLE) && (grant != 2'b00);
    assign capture    = (state == WAIT) && (settleCnt == 4'd0);
    assign req0_ready = (state == IDLE) && grant[0];
    assign req1_ready = (state == IDLE) && grant[1];
    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign busy       = (state != IDLE);

    // alu_a/alu_b/alu_code are the operand registers themselves, so they stay
    // put from ISSUE until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lastGrant    <= 1'b1;
            owner        <= 1'b0;
            settleCnt    <= 4'd0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_code     <= '0;
            alu_enable   <= 1'b0;
            rsp_c        <= '0;
            rsp_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= grant[1] ? req1_a    : req0_a;
                        alu_b      <= grant[1] ? req1_b    : req0_b;
                        alu_code   <= grant[1] ? req1_code : req0_code;
                        owner      <= grant[1];
                        lastGrant  <= grant[1];
                        // Registered toggle: the new level is seen by the ALU during ISSUE
                        alu_enable <= ~alu_enable;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    settleCnt <= 4'(SETTLE_CYCLES - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        rsp_c        <= alu_c;
                        rsp_overflow <= alu_overflow;
                        state        <= RESP;
                    end else begin
                        settleCnt <= settleCnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
            ovf_cnt    <= 16'd0;
        end else begin
            if (accept && grant[0]) begin
                grant_cnt0 <= satInc(grant_cnt0);
            end
            if (accept && grant[1]) begin
                grant_cnt1 <= satInc(grant_cnt1);
            end
            if (capture && alu_overflow) begin
                ovf_cnt <= satInc(ovf_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU
// Define ALU_ARB_STATS_EN to also exercise the counters.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0Valid = 1'b0, req1Valid = 1'b0;
    logic        req0Ready, req1Ready;
    logic [15:0] req0A = '0, req0B = '0, req1A = '0, req1B = '0;
    logic [4:0]  req0Code = '0, req1Code = '0;
    logic        rsp0Valid, rsp1Valid;
    logic        rspReady = 1'b0;
    logic [15:0] rspC;
    logic        rspOvf;
    logic [15:0] aluA, aluB;
    logic [4:0]  aluCode;
    logic        aluEnable;
    logic [15:0] aluC = '0;
    logic        aluOvf = 1'b0;
    logic        busy;

    logic        s3Req0Valid = 1'b0;
    logic        s3Req0Ready, s3Req1Ready;
    logic        s3Rsp0Valid, s3Rsp1Valid;
    logic        s3RspReady = 1'b0;
    logic [15:0] s3RspC, s3AluA, s3AluB;
    logic        s3RspOvf;
    logic [4:0]  s3AluCode;
    logic        s3AluEnable;
    logic [15:0] s3AluC = '0;
    logic        s3AluOvf = 1'b0;
    logic        s3Busy;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grantCnt0, grantCnt1, ovfCnt;
    logic [15:0] s3GrantCnt0, s3GrantCnt1, s3OvfCnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(16), .CODE_W(5), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0Valid), .req1_valid(req1Valid),
        .req0_ready(req0Ready), .req1_ready(req1Ready),
        .req0_a(req0A), .req0_b(req0B), .req1_a(req1A), .req1_b(req1B),
        .req0_code(req0Code), .req1_code(req1Code),
        .rsp0_valid(rsp0Valid), .rsp1_valid(rsp1Valid), .rsp_ready(rspReady),
        .rsp_c(rspC), .rsp_overflow(rspOvf),
        .alu_a(aluA), .alu_b(aluB), .alu_code(aluCode), .alu_enable(aluEnable),
        .alu_c(aluC), .alu_overflow(aluOvf), .busy(busy)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt0(grantCnt0), .grant_cnt1(grantCnt1), .ovf_cnt(ovfCnt)
`endif
    );

    alu_arbiter #(.WIDTH(16), .CODE_W(5), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(s3Req0Valid), .req1_valid(1'b0),
        .req0_ready(s3Req0Ready), .req1_ready(s3Req1Ready),
        .req0_a(16'h0100), .req0_b(16'h0001), .req1_a(16'h0000), .req1_b(16'h0000),
        .req0_code(5'b00001), .req1_code(5'b00000),
        .rsp0_valid(s3Rsp0Valid), .rsp1_valid(s3Rsp1Valid), .rsp_ready(s3RspReady),
        .rsp_c(s3RspC), .rsp_overflow(s3RspOvf),
        .alu_a(s3AluA), .alu_b(s3AluB), .alu_code(s3AluCode), .alu_enable(s3AluEnable),
        .alu_c(s3AluC), .alu_overflow(s3AluOvf), .busy(s3Busy)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt0(s3GrantCnt0), .grant_cnt1(s3GrantCnt1), .ovf_cnt(s3OvfCnt)
`endif
    );

    function automatic logic [16:0] aluRef(input logic [15:0] a, input logic [15:0] b,
                                           input logic [4:0] code);
        logic [15:0] c;
        logic        v;
        c = '0;
        v = 1'b0;
        case (code[4:3])
            ALU_GRP_ARITH: begin
                if (code[0]) begin
                    c = a - b;
                    v = (a[15] != b[15]) && (c[15] != a[15]);
                end else begin
                    c = a + b;
                    v = (a[15] == b[15]) && (c[15] != a[15]);
                end
            end
            ALU_GRP_LOGIC: begin
                case (code[1:0])
                    2'd0:    c = a & b;
                    2'd1:    c = a | b;
                    2'd2:    c = a ^ b;
                    default: c = ~a;
                endcase
            end
            default: c = '0;
        endcase
        return {v, c};
    endfunction

    // The ALU only re-evaluates when its enable level changes
    always @(aluEnable) begin
        #1;
        {aluOvf, aluC} = aluRef(aluA, aluB, aluCode);
    end

    always @(s3AluEnable) begin
        #1;
        {s3AluOvf, s3AluC} = aluRef(s3AluA, s3AluB, s3AluCode);
    end

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic waitReady(input int who, input string tag);
        logic r;
        r = who[0] ? req1Ready : req0Ready;
        for (int i = 0; i < 20 && !r; i++) begin
            @(negedge clk);
            #1;
            r = who[0] ? req1Ready : req0Ready;
        end
        expectEq({tag, "_ready"}, 32'(r), 32'd1);
    endtask

    task automatic waitRsp(input int who, input logic [15:0] expC, input logic expOvf,
                           input string tag);
        logic v;
        v = who[0] ? rsp1Valid : rsp0Valid;
        for (int i = 0; i < 30 && !v; i++) begin
            @(negedge clk);
            #1;
            v = who[0] ? rsp1Valid : rsp0Valid;
        end
        expectEq({tag, "_rspValid"}, 32'(v), 32'd1);
        expectEq({tag, "_otherValid"}, 32'(who[0] ? rsp0Valid : rsp1Valid), 32'd0);
        expectEq({tag, "_rspC"}, 32'(rspC), 32'(expC));
        expectEq({tag, "_rspOvf"}, 32'(rspOvf), 32'(expOvf));
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        #1;
    endtask

    task automatic doOp(input int who, input logic [15:0] a, input logic [15:0] b,
                        input logic [4:0] code, input logic [15:0] expC, input logic expOvf,
                        input string tag);
        if (who[0]) begin
            req1A = a; req1B = b; req1Code = code; req1Valid = 1'b1;
        end else begin
            req0A = a; req0B = b; req0Code = code; req0Valid = 1'b1;
        end
        #1;
        waitReady(who, tag);
        @(negedge clk);
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        #1;
        waitRsp(who, expC, expOvf, tag);
    endtask

    initial begin
        int expOrder[4];
        int got;
        logic sawRsp;
        expOrder = '{0, 1, 0, 1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        expectEq("rst_outputs", {req0Ready, req1Ready, rsp0Valid, rsp1Valid, busy, aluEnable, rspOvf},
                 32'd0);
        expectEq("rst_data", {rspC, aluA}, 32'd0);
        expectEq("rst_code", 32'(aluCode), 32'd0);

        // Single req0 op with exact cycle timing
        req0A = 16'h0003; req0B = 16'h0004; req0Code = 5'b00000; req0Valid = 1'b1;
        #1;
        expectEq("t1_ready0", 32'(req0Ready), 32'd1);
        expectEq("t1_ready1", 32'(req1Ready), 32'd0);
        expectEq("t1_enable_T", 32'(aluEnable), 32'd0);
        @(negedge clk);
        req0Valid = 1'b0;
        #1;
        expectEq("t1_enable_T1", 32'(aluEnable), 32'd1);
        expectEq("t1_aluA_T1", 32'(aluA), 32'h0003);
        expectEq("t1_busy_T1", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        expectEq("t1_valid_T2", 32'(rsp0Valid), 32'd0);
        @(negedge clk);
        #1;
        expectEq("t1_valid_T3", 32'(rsp0Valid), 32'd1);
        expectEq("t1_valid1_T3", 32'(rsp1Valid), 32'd0);
        expectEq("t1_rspC", 32'(rspC), 32'h0007);
        expectEq("t1_rspOvf", 32'(rspOvf), 32'd0);
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        #1;
        expectEq("t1_idle_after_ack", 32'(busy), 32'd0);

        // Tie held across four accepts from a fresh reset
        pulseReset();
        req0A = 16'h000A; req0B = 16'h0005; req0Code = 5'b00001;
        req1A = 16'h00F0; req1B = 16'h0F0F; req1Code = 5'b01001;
        req0Valid = 1'b1;
        req1Valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 20 && !(req0Ready || req1Ready); i++) begin
                @(negedge clk);
                #1;
            end
            expectEq($sformatf("tie%0d_oneReady", k), 32'(req0Ready ^ req1Ready), 32'd1);
            got = req1Ready ? 1 : 0;
            expectEq($sformatf("tie%0d_grant", k), 32'(got), 32'(expOrder[k]));
            @(negedge clk);
            #1;
            if (got == 1) waitRsp(1, 16'h0FFF, 1'b0, $sformatf("tie%0d", k));
            else          waitRsp(0, 16'h0005, 1'b0, $sformatf("tie%0d", k));
        end
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        @(negedge clk);
        #1;

        // Response stall with both requesters pending
        req1A = 16'h1234; req1B = 16'h00FF; req1Code = 5'b01010; req1Valid = 1'b1;
        #1;
        waitReady(1, "stall");
        @(negedge clk);
        req1Valid = 1'b0;
        #1;
        for (int i = 0; i < 20 && !rsp1Valid; i++) begin
            @(negedge clk);
            #1;
        end
        for (int k = 0; k < 5; k++) begin
            req0Valid = 1'b1;
            req1Valid = 1'b1;
            #1;
            expectEq($sformatf("stall%0d_rspC", k), 32'(rspC), 32'h12CB);
            expectEq($sformatf("stall%0d_ctl", k), {req0Ready, req1Ready, busy, rsp1Valid, rsp0Valid},
                     32'b00110);
            @(negedge clk);
        end
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        #1;
        expectEq("stall_idle", {busy, rsp1Valid}, 32'd0);

        // Reset while in WAIT aborts silently
        req0A = 16'h0002; req0B = 16'h0003; req0Code = 5'b00000; req0Valid = 1'b1;
        #1;
        waitReady(0, "abort");
        @(negedge clk);
        req0Valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        expectEq("abort_ctl", {rsp0Valid, rsp1Valid, busy, aluEnable, rspOvf}, 32'd0);
        expectEq("abort_data", {rspC, aluA}, 32'd0);
        rst = 1'b0;
        sawRsp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            sawRsp = sawRsp | rsp0Valid | rsp1Valid;
        end
        expectEq("abort_noRsp", 32'(sawRsp), 32'd0);
        req0Valid = 1'b1;
        req1Valid = 1'b1;
        req1A = 16'h0001; req1B = 16'h0001; req1Code = 5'b00000;
        #1;
        expectEq("abort_tieGrant", {req1Ready, req0Ready}, 32'b01);
        @(negedge clk);
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        #1;
        waitRsp(0, 16'h0005, 1'b0, "abort_next");

        // SETTLE_CYCLES=3 instance
        s3Req0Valid = 1'b1;
        #1;
        expectEq("s3_ready", {s3Req0Ready, s3Req1Ready}, 32'b10);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            s3Req0Valid = 1'b0;
            #1;
            expectEq($sformatf("s3_T%0d", k), {s3Rsp0Valid, s3Rsp1Valid, s3AluA, s3AluB},
                     {2'b00, 16'h0100, 16'h0001});
        end
        @(negedge clk);
        #1;
        expectEq("s3_T5_valid", {s3Rsp0Valid, s3Rsp1Valid, s3Busy}, 32'b101);
        expectEq("s3_T5_rsp", {s3RspOvf, s3RspC}, {1'b0, 16'h00FF});
        expectEq("s3_T5_ops", {s3AluA, s3AluCode}, {16'h0100, 5'b00001});
        s3RspReady = 1'b1;
        @(negedge clk);
        s3RspReady = 1'b0;
        #1;
        expectEq("s3_idle", 32'(s3Busy), 32'd0);

`ifdef ALU_ARB_STATS_EN
        expectEq("s3_stats", {s3GrantCnt0, s3GrantCnt1}, {16'd1, 16'd0});
        expectEq("s3_ovf", 32'(s3OvfCnt), 32'd0);
        pulseReset();
        expectEq("stats_rst", {grantCnt0, grantCnt1}, 32'd0);
        doOp(0, 16'h7FFF, 16'h0001, 5'b00000, 16'h8000, 1'b1, "st_ovf");
        doOp(0, 16'h0001, 16'h0001, 5'b00000, 16'h0002, 1'b0, "st_add");
        doOp(1, 16'h0001, 16'h0002, 5'b01001, 16'h0003, 1'b0, "st_or");
        doOp(0, 16'hF0F0, 16'h00FF, 5'b01000, 16'h00F0, 1'b0, "st_and");
        doOp(1, 16'h0005, 16'h0003, 5'b00001, 16'h0002, 1'b0, "st_sub");
        expectEq("stats_grants", {grantCnt0, grantCnt1}, {16'd3, 16'd2});
        expectEq("stats_ovf", 32'(ovfCnt), 32'd1);
        force dut.grant_cnt0 = 16'hFFFE;
        @(negedge clk);
        release dut.grant_cnt0;
        doOp(0, 16'h0001, 16'h0001, 5'b00000, 16'h0002, 1'b0, "st_sat1");
        expectEq("stats_reachMax", 32'(grantCnt0), 32'h0000FFFF);
        doOp(0, 16'h0001, 16'h0001, 5'b00000, 16'h0002, 1'b0, "st_sat2");
        expectEq("stats_holdMax", 32'(grantCnt0), 32'h0000FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
